// File: rtl/memoria_pkg.sv
// memoria_pkg: shared constants and helpers for the result history memory
package memoria_pkg;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 4;
  function automatic int clog2(input int n);
    int r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
endpackage

// File: rtl/memoria_historico_acumulador.sv
// acumulador_sinalizado: signed add/sub accumulator with sticky two's-complement overflow
module acumulador_sinalizado #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic             sub,
  input  logic [WIDTH-1:0] operando,
  output logic [WIDTH-1:0] acc,
  output logic             overflow
);
  logic [WIDTH-1:0] res;
  logic             ovf;
  always_comb begin
    res = sub ? acc - operando : acc + operando;
    ovf = (res[WIDTH-1] != acc[WIDTH-1]) &&
          (sub ? (acc[WIDTH-1] != operando[WIDTH-1]) : (acc[WIDTH-1] == operando[WIDTH-1]));
  end
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      acc      <= '0;
      overflow <= 1'b0;
    end else if (en) begin
      acc      <= res;
      overflow <= overflow | ovf;
    end
  end
endmodule

// File: rtl/memoria_historico.sv
// memoria_historico: circular history of ALU results with indexed recall and M+/M- accumulator
module memoria_historico
  import memoria_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  localparam int IDX_W = clog2(DEPTH),
  localparam int CNT_W = clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] resultado_entrada,
  input  logic             carregar,
  input  logic             acumular,
  input  logic             subtrair,
  input  logic             limpar,
  input  logic             recuperar,
  input  logic [IDX_W-1:0] indice,
  output logic [WIDTH-1:0] memoria_saida,
  output logic [WIDTH-1:0] valor_recuperado,
  output logic             recuperado_valido,
  output logic             erro_indice,
  output logic [CNT_W-1:0] contagem,
  output logic             vazio,
  output logic             cheio,
  output logic [WIDTH-1:0] acumulador,
  output logic             overflow
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [IDX_W-1:0] wp, ult, rd_ptr;
  logic             idx_ok;
  always_comb begin
    ult           = wp - 1'b1;
    rd_ptr        = ult - indice;
    idx_ok        = CNT_W'(indice) < contagem;
    vazio         = contagem == '0;
    cheio         = contagem == CNT_W'(DEPTH);
    memoria_saida = vazio ? '0 : mem[ult];
  end
  // recall reads pre-store contents, so a same-edge store does not disturb it
  always_ff @(posedge clk) begin
    if (rst || limpar) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wp                <= '0;
      contagem          <= '0;
      valor_recuperado  <= '0;
      recuperado_valido <= 1'b0;
      erro_indice       <= 1'b0;
    end else begin
      recuperado_valido <= recuperar;
      erro_indice       <= recuperar && !idx_ok;
      if (recuperar) valor_recuperado <= idx_ok ? mem[rd_ptr] : '0;
      if (carregar) begin
        mem[wp] <= resultado_entrada;
        wp      <= wp + 1'b1;
        if (!cheio) contagem <= contagem + 1'b1;
      end
    end
  end
  acumulador_sinalizado #(.WIDTH(WIDTH)) u_acc (
    .clk      (clk),
    .rst      (rst),
    .clr      (limpar),
    .en       (carregar && acumular),
    .sub      (subtrair),
    .operando (resultado_entrada),
    .acc      (acumulador),
    .overflow (overflow)
  );
endmodule

// File: tb/tb_memoria_historico.sv
// tb_memoria_historico: table-driven directed check of history, recall and accumulator
module tb_memoria_historico;
  logic       clk = 1'b0;
  logic       rst, carregar, acumular, subtrair, limpar, recuperar;
  logic [7:0] resultado_entrada;
  logic [1:0] indice;
  logic [7:0] memoria_saida, valor_recuperado, acumulador;
  logic       recuperado_valido, erro_indice, vazio, cheio, overflow;
  logic [2:0] contagem;
  int         errors = 0;
  int         checks = 0;

  memoria_historico dut (
    .clk(clk), .rst(rst), .resultado_entrada(resultado_entrada), .carregar(carregar),
    .acumular(acumular), .subtrair(subtrair), .limpar(limpar), .recuperar(recuperar),
    .indice(indice), .memoria_saida(memoria_saida), .valor_recuperado(valor_recuperado),
    .recuperado_valido(recuperado_valido), .erro_indice(erro_indice), .contagem(contagem),
    .vazio(vazio), .cheio(cheio), .acumulador(acumulador), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic rst, lim, car, acu, sub, rec;
    logic [1:0] idx;
    logic [7:0] din;
    logic [7:0] mo, vr;
    logic vld, err;
    logic [2:0] cnt;
    logic [7:0] acc;
    logic ovf;
  } vec_t;

  vec_t v[$];

  function automatic vec_t mk(logic r, logic l, logic c, logic a, logic s, logic q,
                              logic [1:0] i, logic [7:0] d, logic [7:0] mo, logic [7:0] vr,
                              logic vld, logic err, logic [2:0] cnt, logic [7:0] acc, logic ovf);
    vec_t x;
    x.rst = r; x.lim = l; x.car = c; x.acu = a; x.sub = s; x.rec = q; x.idx = i; x.din = d;
    x.mo = mo; x.vr = vr; x.vld = vld; x.err = err; x.cnt = cnt; x.acc = acc; x.ovf = ovf;
    return x;
  endfunction

  task automatic chk(input string name, input int row, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
    end
  endtask

  task automatic drive(input vec_t x);
    rst = x.rst; limpar = x.lim; carregar = x.car; acumular = x.acu; subtrair = x.sub;
    recuperar = x.rec; indice = x.idx; resultado_entrada = x.din;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input int row, input vec_t x);
    chk("memoria_saida", row, memoria_saida, x.mo);
    chk("valor_recuperado", row, valor_recuperado, x.vr);
    chk("recuperado_valido", row, {7'b0, recuperado_valido}, {7'b0, x.vld});
    chk("erro_indice", row, {7'b0, erro_indice}, {7'b0, x.err});
    chk("contagem", row, {5'b0, contagem}, {5'b0, x.cnt});
    chk("vazio", row, {7'b0, vazio}, {7'b0, x.cnt == 3'd0});
    chk("cheio", row, {7'b0, cheio}, {7'b0, x.cnt == 3'd4});
    chk("acumulador", row, acumulador, x.acc);
    chk("overflow", row, {7'b0, overflow}, {7'b0, x.ovf});
  endtask

  initial begin
    //                rst lim car acu sub rec idx din     mo     vr   vld err cnt acc    ovf
    v.push_back(mk(1, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0, 8'h00, 0));
    v.push_back(mk(0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0, 8'h00, 0));
    v.push_back(mk(0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0, 8'h00, 0));
    v.push_back(mk(0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0, 8'h00, 0));
    v.push_back(mk(0, 0, 1, 0, 0, 0, 0, 8'h11, 8'h11, 8'h00, 0, 0, 1, 8'h00, 0));
    v.push_back(mk(0, 0, 1, 0, 0, 0, 0, 8'h22, 8'h22, 8'h00, 0, 0, 2, 8'h00, 0));
    v.push_back(mk(0, 0, 1, 0, 0, 0, 0, 8'h33, 8'h33, 8'h00, 0, 0, 3, 8'h00, 0));
    v.push_back(mk(0, 0, 1, 0, 0, 0, 0, 8'h44, 8'h44, 8'h00, 0, 0, 4, 8'h00, 0));
    v.push_back(mk(0, 0, 1, 0, 0, 0, 0, 8'h55, 8'h55, 8'h00, 0, 0, 4, 8'h00, 0));
    v.push_back(mk(0, 0, 0, 0, 0, 1, 0, 8'h00, 8'h55, 8'h55, 1, 0, 4, 8'h00, 0));
    v.push_back(mk(0, 0, 0, 0, 0, 1, 1, 8'h00, 8'h55, 8'h44, 1, 0, 4, 8'h00, 0));
    v.push_back(mk(0, 0, 0, 0, 0, 1, 2, 8'h00, 8'h55, 8'h33, 1, 0, 4, 8'h00, 0));
    v.push_back(mk(0, 0, 0, 0, 0, 1, 3, 8'h00, 8'h55, 8'h22, 1, 0, 4, 8'h00, 0));
    v.push_back(mk(0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h55, 8'h22, 0, 0, 4, 8'h00, 0));
    v.push_back(mk(0, 0, 1, 0, 0, 1, 0, 8'h66, 8'h66, 8'h55, 1, 0, 4, 8'h00, 0));
    v.push_back(mk(0, 1, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0, 8'h00, 0));
    v.push_back(mk(0, 0, 1, 0, 0, 0, 0, 8'h0A, 8'h0A, 8'h00, 0, 0, 1, 8'h00, 0));
    v.push_back(mk(0, 0, 1, 0, 0, 0, 0, 8'h0B, 8'h0B, 8'h00, 0, 0, 2, 8'h00, 0));
    v.push_back(mk(0, 0, 0, 0, 0, 1, 3, 8'h00, 8'h0B, 8'h00, 1, 1, 2, 8'h00, 0));
    v.push_back(mk(0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h0B, 8'h00, 0, 0, 2, 8'h00, 0));
    v.push_back(mk(0, 1, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0, 8'h00, 0));
    v.push_back(mk(0, 0, 1, 1, 0, 0, 0, 8'h70, 8'h70, 8'h00, 0, 0, 1, 8'h70, 0));
    v.push_back(mk(0, 0, 1, 1, 0, 0, 0, 8'h20, 8'h20, 8'h00, 0, 0, 2, 8'h90, 1));
    v.push_back(mk(0, 0, 1, 1, 1, 0, 0, 8'h10, 8'h10, 8'h00, 0, 0, 3, 8'h80, 1));
    v.push_back(mk(0, 0, 0, 1, 1, 0, 0, 8'h55, 8'h10, 8'h00, 0, 0, 3, 8'h80, 1));
    v.push_back(mk(0, 0, 0, 0, 0, 1, 1, 8'h00, 8'h10, 8'h20, 1, 0, 3, 8'h80, 1));
    v.push_back(mk(0, 1, 0, 0, 0, 1, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0, 8'h00, 0));
    v.push_back(mk(0, 0, 1, 0, 1, 0, 0, 8'h01, 8'h01, 8'h00, 0, 0, 1, 8'h00, 0));
    v.push_back(mk(0, 0, 1, 0, 0, 1, 0, 8'h02, 8'h02, 8'h01, 1, 0, 2, 8'h00, 0));
    v.push_back(mk(1, 0, 1, 0, 0, 1, 0, 8'h99, 8'h00, 8'h00, 0, 0, 0, 8'h00, 0));
    v.push_back(mk(0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0, 8'h00, 0));
    for (int r = 0; r < v.size(); r++) begin
      drive(v[r]);
      check_all(r, v[r]);
    end
    // negative-operand subtraction: 0 - (-128) overflows, then limpar clears the sticky flag
    drive(mk(0, 0, 1, 1, 1, 0, 0, 8'h80, 0, 0, 0, 0, 0, 0, 0));
    chk("acc_sub_min", 100, acumulador, 8'h80);
    chk("ovf_sub_min", 100, {7'b0, overflow}, 8'h01);
    drive(mk(0, 0, 1, 1, 0, 0, 0, 8'hF0, 0, 0, 0, 0, 0, 0, 0));
    chk("acc_wrap_neg", 101, acumulador, 8'h70);
    chk("ovf_sticky", 101, {7'b0, overflow}, 8'h01);
    drive(mk(0, 1, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0));
    chk("ovf_cleared", 102, {7'b0, overflow}, 8'h00);
    chk("acc_cleared", 102, acumulador, 8'h00);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/memoria_historico.md
Name: memoria_historico

Overview:
- Parametrised result memory for the ALU datapath.
- Keeps the last DEPTH results in a circular history buffer and supports indexed recall with registered output.
- Keeps a signed running accumulator (M+/M-) with a sticky overflow flag.
- Sits between the ALU result bus and the display/operand-select muxes; generalises the single-entry memory register.

Parameters:
- WIDTH, 8, data width of results, accumulator and recall output.
- DEPTH, 4, number of history entries; power of two, >= 2.
- Derived localparams: IDX_W = clog2(DEPTH); CNT_W = clog2(DEPTH+1).

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- rst  in  1  reset; synchronous and active-high.
- resultado_entrada  in  WIDTH  ALU result to store.
- carregar  in  1  store resultado_entrada into history this cycle.
- acumular  in  1  with carregar: also add/subtract entry into accumulator.
- subtrair  in  1  with acumular: subtract instead of add.
- limpar  in  1  clear history, count, accumulator and overflow.
- recuperar  in  1  request recall of entry indice.
- indice  in  IDX_W  recall index, 0 = most recent.
- memoria_saida  out  WIDTH  most recent stored entry (0 when empty).
- valor_recuperado  out  WIDTH  registered recall data.
- recuperado_valido  out  1  one-cycle pulse: valor_recuperado updated.
- erro_indice  out  1  one-cycle pulse: recall index >= contagem.
- contagem  out  CNT_W  valid entries, 0..DEPTH.
- vazio  out  1  contagem == 0.
- cheio  out  1  contagem == DEPTH.
- acumulador  out  WIDTH  signed running accumulator.
- overflow  out  1  sticky two's-complement overflow of accumulator.

Behaviour:
- Reset (rst=1 at edge): all entries, write pointer, contagem, acumulador, valor_recuperado = 0; recuperado_valido, erro_indice, overflow = 0; vazio=1, cheio=0. rst overrides all other inputs.
- Priority below reset: limpar > carregar. limpar behaves as reset and also discards any same-cycle recuperar; no pulses issue.
- Store (carregar=1): entry[wp] <= resultado_entrada; wp <= wp+1 mod DEPTH; contagem <= min(contagem+1, DEPTH). When cheio, overwrite the oldest entry; contagem stays DEPTH.
- memoria_saida = entry[wp-1 mod DEPTH] when contagem>0, else 0. It is combinational from registers, so the new value is visible the cycle after the store edge.
- Recall (recuperar=1, 1-cycle latency):
  - If indice < contagem: valor_recuperado <= entry[(wp-1-indice) mod DEPTH]; recuperado_valido pulses next cycle.
  - Otherwise: valor_recuperado <= 0; recuperado_valido and erro_indice both pulse.
  - valor_recuperado holds between recalls.
- Simultaneous recuperar + carregar: recall uses pre-store contents and pre-store contagem (indice 0 returns the previous latest).
- Accumulator (carregar=1 and acumular=1):
  - acc <= acc ± resultado_entrada, signed, mod 2^WIDTH wrap.
  - overflow set when operand signs and result sign indicate signed overflow; sticky until limpar/rst.
  - acumular without carregar does nothing; subtrair is ignored unless acumular=1.
- vazio/cheio are derived combinationally from contagem.
- No state machine beyond pointer/count; all outputs registered or decoded from registers. No combinational path from inputs to outputs.

Decomposition:
- Shared package memoria_pkg: clog2 function and the default WIDTH/DEPTH constants.
- One sub-module: acumulador_sinalizado (WIDTH param; add/sub, enable, clear, sticky signed-overflow flag).
- History array, pointer and recall logic stay in the top module.

Test Plan:
- Reset then idle 3 cycles -> memoria_saida=0, contagem=0, vazio=1, acumulador=0, no pulses.
- Store 0x11,0x22,0x33,0x44,0x55 (DEPTH=4) -> cheio=1, contagem=4, memoria_saida=0x55; recall indices 0..3 -> 0x55,0x44,0x33,0x22, each one cycle after request.
- After 2 stores (0x0A,0x0B), recall indice=3 -> valor_recuperado=0, recuperado_valido=1 and erro_indice=1 for exactly one cycle.
- Store 0x66 with recuperar=1, indice=0 on the same edge, prior latest 0x55 -> valor_recuperado=0x55; next cycle memoria_saida=0x66.
- Accumulate +0x70 then +0x20 (WIDTH=8) -> acumulador=0x90, overflow=1. Then subtract 0x10 -> acumulador=0x80, overflow stays 1. Then limpar -> all 0, vazio=1.
- Assert rst mid-sequence with carregar=1 and recuperar=1 -> next cycle all outputs at reset values; the store is dropped and no recall pulse issues.
